// File: rtl/onchip_loader_pkg.sv
// rtl/onchip_loader_pkg.sv - shared types and defaults for the on-chip memory stream loader
// Purpose: FSM state enum, default memory geometry and packing width.
package onchip_loader_pkg;

  localparam int DEFAULT_DEPTH  = 25600;
  localparam int DEFAULT_ADDR_W = 15;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs accepted stream bytes little-endian into a 32-bit word
// Purpose: byte k of a word (k = 0..3, in arrival order) lands in word[8k+7:8k].
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear_i         restart packing at byte 0 (new load)
//   in_data_i       stream byte
//   in_fire_i       byte accepted this cycle
//   word_o          packed word (complete the cycle after word_valid_o)
//   word_valid_o    the byte accepted this cycle completes the word
module byte_word_packer
  import onchip_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_fire_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (in_fire_i) begin
      cnt_d = cnt_q + 2'd1;
      word_d[{cnt_q, 3'b000} +: 8] = in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Combinational so the FSM can leave FILL before a fifth byte is accepted.
  assign word_valid_o = in_fire_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_o       = word_q;

endmodule

// File: rtl/onchip_mem_stream_loader.sv
// rtl/onchip_mem_stream_loader.sv - byte stream to on-chip program memory loader with readback verify
// Purpose: packs a byte stream into words, writes them at consecutive addresses
// from base_addr, reads the region back and compares running sums.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, base_addr, length    load request (sampled in IDLE only)
//   in_data, in_valid, in_ready byte stream handshake
//   mem_*                       Avalon-MM master towards the memory
//   busy, done, error, checksum status to the boot controller
module onchip_mem_stream_loader
  import onchip_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       widx_q, widx_d;
  logic [15:0]       ridx_q, ridx_d;
  logic [31:0]       checksum_q, checksum_d;
  logic [31:0]       vsum_q, vsum_d;
  logic              error_q, error_d;

  logic              pack_clear;
  logic              in_fire;
  logic [31:0]       pack_word;
  logic              pack_word_valid;
  logic [31:0]       range_end;
  logic [15:0]       last_idx;

  assign in_fire   = in_valid && in_ready;
  // Widened so base+length cannot overflow before the comparison.
  assign range_end = 32'(base_addr) + 32'(length);
  assign last_idx  = len_q - 16'd1;

  byte_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pack_clear),
    .in_data_i    (in_data),
    .in_fire_i    (in_fire),
    .word_o       (pack_word),
    .word_valid_o (pack_word_valid)
  );

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    len_d          = len_q;
    widx_d         = widx_q;
    ridx_d         = ridx_q;
    checksum_d     = checksum_q;
    vsum_d         = vsum_q;
    error_d        = error_q;
    pack_clear     = 1'b0;
    in_ready       = 1'b0;
    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          len_d      = length;
          widx_d     = '0;
          ridx_d     = '0;
          checksum_d = '0;
          vsum_d     = '0;
          error_d    = 1'b0;
          pack_clear = 1'b1;
          if (length == 16'd0) begin
            state_d = ST_FINISH;
          end else if (range_end > 32'(DEPTH)) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        in_ready = 1'b1;
        if (pack_word_valid) state_d = ST_WRITE;
      end

      ST_WRITE: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_byteenable = 4'hF;
        mem_address    = base_q + ADDR_W'(widx_q);
        mem_writedata  = pack_word;
        checksum_d     = checksum_q + pack_word;
        if (widx_q == last_idx) begin
          ridx_d  = '0;
          state_d = ST_VERIFY;
        end else begin
          widx_d  = widx_q + 16'd1;
          state_d = ST_FILL;
        end
      end

      ST_VERIFY: begin
        mem_chipselect = 1'b1;
        mem_address    = base_q + ADDR_W'(ridx_q);
        // Read data lags the address by one cycle; nothing is pending yet on index 0.
        if (ridx_q != 16'd0) vsum_d = vsum_q + mem_readdata;
        if (ridx_q == last_idx) state_d = ST_CHECK;
        else                    ridx_d  = ridx_q + 16'd1;
      end

      ST_CHECK: begin
        if ((vsum_q + mem_readdata) != checksum_q) error_d = 1'b1;
        state_d = ST_FINISH;
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      widx_q     <= '0;
      ridx_q     <= '0;
      checksum_q <= '0;
      vsum_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      ridx_q     <= ridx_d;
      checksum_q <= checksum_d;
      vsum_q     <= vsum_d;
      error_q    <= error_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign mem_clken = busy;
  assign error     = error_q;
  assign checksum  = checksum_q;

endmodule

// File: doc/onchip_mem_stream_loader.md
# onchip_mem_stream_loader

Upstream loader for the 32-bit single-port on-chip program memory. Accepts a byte stream (UART/JTAG bridge), packs bytes little-endian into 32-bit words, writes them at consecutive word addresses, then reads the region back and compares a running checksum. It drives the memory's Avalon-MM slave port directly while the Nios II core is held in reset, and reports done/error to the boot controller.

## Interface
Parameters:
- DEPTH, 25600: memory depth in 32-bit words
- ADDR_W, 15: word-address width

Ports:
- clk  in  1  system clock; only clock in the block
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load; ignored while busy
- base_addr  in  ADDR_W  first word address, sampled on start
- length  in  16  number of words to load, sampled on start
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte this cycle when in_valid & in_ready
- mem_address  out  ADDR_W  memory word address
- mem_byteenable  out  4  always 4'hF while writing
- mem_chipselect  out  1  memory select
- mem_write  out  1  write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  memory clock enable
- mem_readdata  in  32  memory read data, valid 1 cycle after address
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse at end of load
- error  out  1  sticky until next start: range or checksum failure
- checksum  out  32  modulo-2^32 sum of written words

## Operation
- States: IDLE, FILL, WRITE, VERIFY, CHECK, FINISH.
- IDLE: in_ready=0; on start, latch base_addr/length, clear checksum/error, byte count=0. length=0 → FINISH. base_addr+length > DEPTH → error=1, FINISH (no writes). Else → FILL.
- FILL: in_ready=1. Accepted byte k (0..3) lands in writedata[8k+7:8k]. On 4th accepted byte → WRITE.
- WRITE: one cycle; mem_chipselect=1, mem_write=1, byteenable=4'hF, address=base+word index; checksum += word. If last word → VERIFY with read index=0, else word index+1 → FILL.
- VERIFY: mem_chipselect=1, mem_write=0; address = base+read index, advanced every cycle; readdata of previous cycle added to verify sum. After last address issued → CHECK.
- CHECK: adds final readdata; compares verify sum to checksum; mismatch → error=1. → FINISH.
- FINISH: done=1 for one cycle, → IDLE.
- Addresses never wrap: range check at start guarantees base+length-1 ≤ DEPTH-1.
- Sum arithmetic: 32-bit unsigned, carry discarded.
- start in any state but IDLE ignored; in_valid in any state but FILL ignored (in_ready=0).
- mem_clken = 1 whenever busy, 0 in IDLE.

## Timing
- Reset values: in_ready=0, mem_* all 0 (address 0, byteenable 0), busy=0, done=0, error=0, checksum=0; state IDLE. Reset mid-load aborts immediately; memory contents undefined beyond words already written.
- start sampled at edge N → busy=1 and FILL (in_ready=1) at N+1.
- Write throughput: 4 accepted bytes + 1 WRITE cycle = 5 cycles/word at full in_valid.
- Write issued the cycle after the 4th byte handshake.
- Read latency: 1 cycle (address registered in RAM, q unregistered). VERIFY takes length cycles, CHECK 1, FINISH 1.
- Total with continuous input: 5·L + L + 2 cycles after FILL entry; done asserted in the last one.
- error valid from the cycle done pulses; stays until next accepted start.
- in_valid gaps stall FILL with no timeout; byte count held.

## Structure
- Package onchip_loader_pkg: state enum, DEPTH and ADDR_W defaults, BYTES_PER_WORD=4.
- Sub-module byte_word_packer: 2-bit byte counter, 32-bit shift/place register, word_valid pulse; FSM, address counters and checksum in top.

## Test plan
- Load base=0, length=2, bytes 01 02 03 04 05 06 07 08 → writes 0x04030201 @0, 0x08070605 @1; checksum=0x0C0A0806; done, error=0.
- length=0 → done 2 cycles after start, no mem_write, error=0.
- base=25599, length=2 → error=1, done, no mem_write asserted.
- Memory model corrupts word @1 on readback (bit flip) → error=1 at done; checksum unchanged.
- Random in_valid gaps, length=64 → contents match reference; no byte dropped or duplicated; start pulse mid-load ignored.
- reset asserted during FILL of word 3 → next cycle all outputs at reset values; new start completes correctly.
